store_write_buffer: RTL and testbench
=====================================

Name: store_write_buffer

Overview:
- Store-side counterpart of the writeback load/LUI selection path.
- Accepts SB/SH/SW requests from the MEM stage and aligns the store data to the word lane.
- Generates byte enables, queues entries in a small FIFO and drains them to data memory over a we/ack handshake.
- Flags pending-store address hits so the hazard unit can stall a load.

Parameters:
NBITS, 32, data word width (fixed 32 for byte-lane logic)
ADDR_BITS, 32, byte address width
DEPTH, 4, FIFO entries; power of 2, >= 2

Ports:
i_clk  input  1  clock, rising edge
i_reset_n  input  1  reset, asynchronous, active-low
i_store_valid  input  1  store request this cycle
i_store_type  input  2  00 SB, 01 SH, 10 SW, 11 reserved
i_addr  input  ADDR_BITS  store byte address
i_data  input  NBITS  rt register value, unaligned
o_store_ready  output  1  buffer can accept a store
o_misaligned  output  1  registered 1-cycle pulse: rejected store
i_mem_ack  input  1  data memory accepted current write
o_mem_we  output  1  write request to data memory
o_mem_addr  output  ADDR_BITS  word-aligned address, bits[1:0]=00
o_mem_wdata  output  NBITS  lane-aligned write data
o_mem_be  output  4  byte enables, bit n = byte n
i_load_addr  input  ADDR_BITS  address of load in MEM stage
o_load_hit  output  1  a pending entry matches the load word
o_empty  output  1  FIFO empty
o_count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, while i_reset_n=0):
  - FIFO pointers and count go to 0; state goes to IDLE.
  - o_mem_we=0; o_mem_addr, o_mem_wdata and o_mem_be are 0.
  - o_misaligned=0, o_empty=1, o_count=0.
  - Reset mid-write drops all entries; no ack is awaited afterwards.
- o_store_ready = (count < DEPTH). It does not depend on a same-cycle pop.
- Accept condition: i_store_valid & o_store_ready & aligned.
- Alignment rules:
  - SB is always aligned.
  - SH requires addr[0]=0.
  - SW requires addr[1:0]=00.
  - Type 11 is always rejected.
- A rejected store, even when o_store_ready=0, is not enqueued; o_misaligned=1 on the next cycle only.
- Lane alignment (little-endian):
  - SB: wdata = {4{data[7:0]}}, be = 0001 << addr[1:0].
  - SH: wdata = {2{data[15:0]}}, be = addr[1] ? 1100 : 0011.
  - SW: wdata = data, be = 1111.
- Entry contents: {addr[ADDR_BITS-1:2], wdata, be}.
- Drain FSM:
  - IDLE: mem outputs are 0. If count != 0 at the clock edge, go to WRITE; first o_mem_we is 1 cycle after the first enqueue.
  - WRITE: o_mem_we=1. o_mem_addr, o_mem_wdata and o_mem_be come from the head entry and stay stable until ack.
  - On i_mem_ack in WRITE: pop the head. Stay in WRITE if count_after_pop > 0, otherwise go to IDLE.
  - Back-to-back acks drain 1 entry per cycle.
  - i_mem_ack in IDLE is ignored.
- Simultaneous push and pop: count is unchanged; the pushed entry goes to the tail.
- Pointers wrap modulo DEPTH.
- o_load_hit (combinational): OR over valid entries of entry.addr == i_load_addr[ADDR_BITS-1:2]. It includes the head while in WRITE and excludes the same-cycle incoming store.
- o_empty = (count==0). o_count is the registered count.

Optional Feature:
- Macro: STORE_COALESCE_EN.
- Defined: an aligned store whose word address equals the most recently enqueued entry is merged into that entry, provided that entry is not the head while in WRITE.
  - Merge: be |= new_be; bytes with new_be=1 take the new data.
  - Count is unchanged.
  - A merge is accepted even when full: o_store_ready = (count<DEPTH) | merge_possible, evaluated combinationally from i_addr and i_store_type.
- Undefined: every accepted store takes a new entry; there is no merge logic.

Test Plan:
- Reset, SW addr 0x10, data 0xDEADBEEF, ack held 1 -> next cycle o_mem_we=1, addr 0x10, wdata 0xDEADBEEF, be 1111; following cycle o_mem_we=0, o_empty=1.
- SB addr 0x23, data 0x000000A5 -> wdata 0xA5A5A5A5, be 1000, addr 0x20; SH addr 0x22, data 0x1234 -> wdata 0x12341234, be 1100.
- SW addr 0x06 and SH addr 0x05 -> each produces one-cycle o_misaligned; count stays 0; o_mem_we never asserts.
- Ack held 0, enqueue 4 SWs -> o_count=4, o_store_ready=0; a 5th valid store is dropped. Then pulse ack 4 times -> entries drained in FIFO order, IDLE after the last pop.
- Full buffer, assert store valid and ack in the same cycle -> store dropped (ready=0), count goes to 3. With count=2, push plus ack together -> count stays 2.
- Entry pending at addr 0x40, i_load_addr 0x43 -> o_load_hit=1; 0x44 -> 0. Reset asserted mid-WRITE -> o_mem_we=0 immediately, o_count=0, o_load_hit=0.
- STORE_COALESCE_EN defined, ack held 0: SB 0x30 (0x11) then SB 0x31 (0x22) enqueued while the 0x30 entry is not the WRITE head -> single entry, be 0011, bytes[15:0]=0x2211. Undefined -> two entries.

Source files
------------

// File: rtl/store_write_buffer.sv
// Store write buffer: aligns SB/SH/SW data to word lanes, queues entries and drains them over we/ack.
// Define STORE_COALESCE_EN to merge a store into the most recently enqueued entry of the same word.
module store_write_buffer #(
  parameter int NBITS     = 32,
  parameter int ADDR_BITS = 32,
  parameter int DEPTH     = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_store_valid,
  input  logic [1:0]               i_store_type,
  input  logic [ADDR_BITS-1:0]     i_addr,
  input  logic [NBITS-1:0]         i_data,
  output logic                     o_store_ready,
  output logic                     o_misaligned,
  input  logic                     i_mem_ack,
  output logic                     o_mem_we,
  output logic [ADDR_BITS-1:0]     o_mem_addr,
  output logic [NBITS-1:0]         o_mem_wdata,
  output logic [3:0]               o_mem_be,
  input  logic [ADDR_BITS-1:0]     i_load_addr,
  output logic                     o_load_hit,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WA = ADDR_BITS - 2;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [0:0] {IDLE = 1'b0, WRITE = 1'b1} state_t;

  function automatic logic is_aligned(input logic [1:0] st, input logic [1:0] a);
    case (st)
      2'b00:   return 1'b1;
      2'b01:   return ~a[0];
      2'b10:   return (a == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] st, input logic [1:0] a);
    case (st)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [NBITS-1:0] lane_data(input logic [1:0] st, input logic [NBITS-1:0] d);
    case (st)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  state_t            state_r;
  logic [WA-1:0]     addr_q_r [DEPTH];
  logic [NBITS-1:0]  data_q_r [DEPTH];
  logic [3:0]        be_q_r   [DEPTH];
  logic [PW-1:0]     wr_ptr_r, rd_ptr_r, last_ptr_s, view_ptr_s;
  logic [PW-1:0]     off_s [DEPTH];
  logic [CW-1:0]     count_r, count_next_s;
  logic              misaligned_r, mem_we_r;
  logic [ADDR_BITS-1:0] mem_addr_r;
  logic [NBITS-1:0]  mem_wdata_r;
  logic [3:0]        mem_be_r;

  logic [WA-1:0]     new_addr_s, view_addr_s;
  logic [NBITS-1:0]  new_data_s, merged_data_s, view_data_s;
  logic [3:0]        new_be_s, merged_be_s, view_be_s;
  logic              aligned_s, merge_s, ready_s, accept_s, push_s, do_merge_s, pop_s, hit_s;
  logic              unused_s;

  assign new_addr_s   = i_addr[ADDR_BITS-1:2];
  assign new_data_s   = lane_data(i_store_type, i_data);
  assign new_be_s     = lane_be(i_store_type, i_addr[1:0]);
  assign aligned_s    = is_aligned(i_store_type, i_addr[1:0]);
  assign last_ptr_s   = wr_ptr_r - PTR_ONE;
  assign ready_s      = (count_r < CNT_FULL) | merge_s;
  assign accept_s     = i_store_valid & ready_s & aligned_s;
  assign do_merge_s   = accept_s & merge_s;
  assign push_s       = accept_s & ~merge_s;
  assign pop_s        = (state_r == WRITE) & i_mem_ack;
  assign count_next_s = count_r + CW'(push_s) - CW'(pop_s);
  assign unused_s     = ^i_load_addr[1:0];

`ifdef STORE_COALESCE_EN
  // Merge into the newest entry unless that entry is already being presented to memory.
  always_comb begin
    merge_s       = 1'b0;
    merged_be_s   = be_q_r[last_ptr_s] | new_be_s;
    merged_data_s = data_q_r[last_ptr_s];
    if (aligned_s && (count_r != CNT_ZERO) && (addr_q_r[last_ptr_s] == new_addr_s)
        && !((state_r == WRITE) && (count_r == CNT_ONE))) begin
      merge_s = 1'b1;
    end else begin
      merge_s = 1'b0;
    end
    for (int b = 0; b < 4; b++) begin
      merged_data_s[8*b +: 8] = new_be_s[b] ? new_data_s[8*b +: 8] : data_q_r[last_ptr_s][8*b +: 8];
    end
  end
`else
  assign merge_s       = 1'b0;
  assign merged_be_s   = 4'b0000;
  assign merged_data_s = {NBITS{1'b0}};
`endif

  // Entry the FSM loads next, with same-cycle push/merge forwarded so it is never stale.
  always_comb begin
    view_ptr_s = rd_ptr_r;
    if (state_r == WRITE) view_ptr_s = rd_ptr_r + PTR_ONE;
    else                  view_ptr_s = rd_ptr_r;
    if (push_s && (wr_ptr_r == view_ptr_s)) begin
      view_addr_s = new_addr_s;
      view_data_s = new_data_s;
      view_be_s   = new_be_s;
    end else if (do_merge_s && (last_ptr_s == view_ptr_s)) begin
      view_addr_s = addr_q_r[view_ptr_s];
      view_data_s = merged_data_s;
      view_be_s   = merged_be_s;
    end else begin
      view_addr_s = addr_q_r[view_ptr_s];
      view_data_s = data_q_r[view_ptr_s];
      view_be_s   = be_q_r[view_ptr_s];
    end
  end

  // Word-address match against every occupied entry, head included.
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off_s[i] = PW'(i) - rd_ptr_r;
      hit_s    = hit_s | (({1'b0, off_s[i]} < count_r) && (addr_q_r[i] == i_load_addr[ADDR_BITS-1:2]));
    end
  end

  // FIFO storage, pointers, occupancy and misalignment pulse.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      count_r      <= CNT_ZERO;
      misaligned_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q_r[i] <= {WA{1'b0}};
        data_q_r[i] <= {NBITS{1'b0}};
        be_q_r[i]   <= 4'b0000;
      end
    end else begin
      misaligned_r <= i_store_valid & ~aligned_s;
      count_r      <= count_next_s;
      if (push_s) begin
        addr_q_r[wr_ptr_r] <= new_addr_s;
        data_q_r[wr_ptr_r] <= new_data_s;
        be_q_r[wr_ptr_r]   <= new_be_s;
        wr_ptr_r           <= wr_ptr_r + PTR_ONE;
      end
      if (do_merge_s) begin
        data_q_r[last_ptr_s] <= merged_data_s;
        be_q_r[last_ptr_s]   <= merged_be_s;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Drain FSM with registered memory-side outputs held stable until ack.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r     <= IDLE;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_BITS{1'b0}};
      mem_wdata_r <= {NBITS{1'b0}};
      mem_be_r    <= 4'b0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (count_r != CNT_ZERO) begin
            state_r     <= WRITE;
            mem_we_r    <= 1'b1;
            mem_addr_r  <= {view_addr_s, 2'b00};
            mem_wdata_r <= view_data_s;
            mem_be_r    <= view_be_s;
          end else begin
            state_r     <= IDLE;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_BITS{1'b0}};
            mem_wdata_r <= {NBITS{1'b0}};
            mem_be_r    <= 4'b0000;
          end
        end
        WRITE: begin
          if (i_mem_ack && (count_next_s != CNT_ZERO)) begin
            state_r     <= WRITE;
            mem_addr_r  <= {view_addr_s, 2'b00};
            mem_wdata_r <= view_data_s;
            mem_be_r    <= view_be_s;
          end else if (i_mem_ack) begin
            state_r     <= IDLE;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_BITS{1'b0}};
            mem_wdata_r <= {NBITS{1'b0}};
            mem_be_r    <= 4'b0000;
          end else begin
            state_r     <= WRITE;
          end
        end
        default: begin
          state_r     <= IDLE;
          mem_we_r    <= 1'b0;
          mem_addr_r  <= {ADDR_BITS{1'b0}};
          mem_wdata_r <= {NBITS{1'b0}};
          mem_be_r    <= 4'b0000;
        end
      endcase
    end
  end

  assign o_store_ready = ready_s;
  assign o_misaligned  = misaligned_r;
  assign o_mem_we      = mem_we_r;
  assign o_mem_addr    = mem_addr_r;
  assign o_mem_wdata   = mem_wdata_r;
  assign o_mem_be      = mem_be_r;
  assign o_load_hit    = hit_s;
  assign o_empty       = (count_r == CNT_ZERO);
  assign o_count       = count_r;

endmodule

// File: tb/tb_store_write_buffer.sv
// Scoreboard bench for store_write_buffer: expected memory writes are queued at stimulus time
// and checked by a negedge monitor whenever a write is acknowledged.
module tb_store_write_buffer;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_store_valid;
  logic [1:0]  i_store_type;
  logic [31:0] i_addr, i_data, i_load_addr;
  logic        o_store_ready, o_misaligned, i_mem_ack, o_mem_we, o_load_hit, o_empty;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic [2:0]  o_count;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  mis_seen = 0;
  int  mis_exp = 0;

  store_write_buffer #(.NBITS(32), .ADDR_BITS(32), .DEPTH(4)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_store_valid(i_store_valid), .i_store_type(i_store_type),
    .i_addr(i_addr), .i_data(i_data),
    .o_store_ready(o_store_ready), .o_misaligned(o_misaligned),
    .i_mem_ack(i_mem_ack), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_load_addr(i_load_addr), .o_load_hit(o_load_hit),
    .o_empty(o_empty), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic store(input logic [1:0] st, input logic [31:0] a, input logic [31:0] d);
    i_store_valid = 1'b1;
    i_store_type  = st;
    i_addr        = a;
    i_data        = d;
    tick();
    i_store_valid = 1'b0;
    i_store_type  = 2'b00;
    i_addr        = 32'h0;
    i_data        = 32'h0;
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_q.push_back({a, d, be});
  endtask

  // Monitor: an acknowledged write must match the oldest expected write.
  always @(negedge i_clk) begin
    if (i_reset_n && o_mem_we && i_mem_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h be %b, none expected",
                 o_mem_addr, o_mem_wdata, o_mem_be);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({o_mem_addr, o_mem_wdata, o_mem_be} !== e) begin
          errors++;
          $display("FAIL mem_write: got addr 0x%08h data 0x%08h be %b expected addr 0x%08h data 0x%08h be %b",
                   o_mem_addr, o_mem_wdata, o_mem_be, e.addr, e.data, e.be);
        end
      end
    end
    if (i_reset_n && o_misaligned) mis_seen++;
  end

  initial begin
    i_reset_n = 1'b0; i_store_valid = 1'b0; i_store_type = 2'b00;
    i_addr = 32'h0; i_data = 32'h0; i_load_addr = 32'h0; i_mem_ack = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_we", o_mem_we, 1'b0);
    check("rst_addr", o_mem_addr, 32'h0);
    check("rst_wdata", o_mem_wdata, 32'h0);
    check("rst_be", o_mem_be, 4'h0);
    check("rst_empty", o_empty, 1'b1);
    check("rst_count", o_count, 3'd0);
    check("rst_mis", o_misaligned, 1'b0);
    check("rst_ready", o_store_ready, 1'b1);
    i_reset_n = 1'b1;
    tick();

    // Single SW with ack held high
    i_mem_ack = 1'b1;
    expect_wr(32'h10, 32'hDEADBEEF, 4'b1111);
    store(2'b10, 32'h10, 32'hDEADBEEF);
    check("sw_we_latency", o_mem_we, 1'b0);
    check("sw_count", o_count, 3'd1);
    tick();
    check("sw_we", o_mem_we, 1'b1);
    check("sw_addr", o_mem_addr, 32'h10);
    tick();
    check("sw_we_done", o_mem_we, 1'b0);
    check("sw_empty", o_empty, 1'b1);

    // SB then SH to the same word, SH arrives while SB is the WRITE head
    expect_wr(32'h20, 32'hA5A5A5A5, 4'b1000);
    expect_wr(32'h20, 32'h12341234, 4'b1100);
    store(2'b00, 32'h23, 32'h000000A5);
    tick();
    store(2'b01, 32'h22, 32'h00001234);
    check("sbsh_count", o_count, 3'd1);
    tick();
    check("sbsh_empty", o_empty, 1'b1);
    check("sbsh_we", o_mem_we, 1'b0);

    // Misaligned and reserved stores
    store(2'b10, 32'h06, 32'h11223344);
    mis_exp++;
    check("mis_sw", o_misaligned, 1'b1);
    check("mis_sw_count", o_count, 3'd0);
    store(2'b01, 32'h05, 32'h00005678);
    mis_exp++;
    check("mis_sh", o_misaligned, 1'b1);
    store(2'b11, 32'h00, 32'h0000FFFF);
    mis_exp++;
    check("mis_rsv", o_misaligned, 1'b1);
    tick();
    check("mis_clear", o_misaligned, 1'b0);
    check("mis_we", o_mem_we, 1'b0);
    check("mis_count", o_count, 3'd0);

    // Fill with ack low, overflow drop, then drain with mixed push/pop
    i_mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect_wr(32'h100 + 32'(4 * k), 32'hA0000001 + 32'(k), 4'b1111);
      store(2'b10, 32'h100 + 32'(4 * k), 32'hA0000001 + 32'(k));
    end
    check("full_count", o_count, 3'd4);
    check("full_ready", o_store_ready, 1'b0);
    check("full_head", o_mem_addr, 32'h100);
    store(2'b10, 32'h110, 32'hBAD00005);
    check("full_drop", o_count, 3'd4);
    check("full_no_mis", o_misaligned, 1'b0);
    i_mem_ack = 1'b1;
    store(2'b10, 32'h200, 32'hBAD00006);
    i_mem_ack = 1'b0;
    check("full_push_ack", o_count, 3'd3);
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
    check("pop_count", o_count, 3'd2);
    expect_wr(32'h120, 32'hC0000120, 4'b1111);
    i_mem_ack = 1'b1;
    store(2'b10, 32'h120, 32'hC0000120);
    check("push_pop_count", o_count, 3'd2);
    tick();
    tick();
    check("drain_empty", o_empty, 1'b1);
    check("drain_we", o_mem_we, 1'b0);

    // Load hit against a pending entry, then reset mid-WRITE
    i_mem_ack = 1'b0;
    store(2'b10, 32'h40, 32'h55555555);
    i_load_addr = 32'h43;
    #1;
    check("hit_43", o_load_hit, 1'b1);
    i_load_addr = 32'h44;
    #1;
    check("hit_44", o_load_hit, 1'b0);
    i_load_addr = 32'h43;
    tick();
    check("hit_head_we", o_mem_we, 1'b1);
    check("hit_head", o_load_hit, 1'b1);
    #2;
    i_reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_we", o_mem_we, 1'b0);
    check("midrst_count", o_count, 3'd0);
    check("midrst_hit", o_load_hit, 1'b0);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    tick();
    check("postrst_we", o_mem_we, 1'b0);

    // Two byte stores into the same word while the entry is not the WRITE head
`ifdef STORE_COALESCE_EN
    expect_wr(32'h30, 32'h11112211, 4'b0011);
`else
    expect_wr(32'h30, 32'h11111111, 4'b0001);
    expect_wr(32'h30, 32'h22222222, 4'b0010);
`endif
    store(2'b00, 32'h30, 32'h00000011);
    store(2'b00, 32'h31, 32'h00000022);
`ifdef STORE_COALESCE_EN
    check("coal_count", o_count, 3'd1);
`else
    check("coal_count", o_count, 3'd2);
`endif
    i_mem_ack = 1'b1;
    repeat (3) tick();
    check("coal_empty", o_empty, 1'b1);

    repeat (3) tick();
    check("sb_left", exp_q.size(), 32'd0);
    check("mis_pulses", mis_seen, mis_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
